// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath selects and memory requests, counts retired instructions, traps illegal opcodes.
module multicycle_control #(
  parameter bit RESET_PC_LOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        pc_load,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  logic [2:0]  cur_state, nxt_state;
  logic        boot;
  logic [31:0] ret_count;

  logic       d_mem_req, d_mem_we, d_addr_sel, d_ir_load, d_pc_load;
  logic [1:0] d_pc_src, d_alu_op, d_wb_sel;
  logic       d_alu_src_a, d_alu_src_b, d_reg_write, d_illegal;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI: is_legal = 1'b1;
      default:                               is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    nxt_state   = cur_state;
    d_mem_req   = 1'b0;
    d_mem_we    = 1'b0;
    d_addr_sel  = 1'b0;
    d_ir_load   = 1'b0;
    d_pc_load   = 1'b0;
    d_pc_src    = 2'b00;
    d_alu_src_a = 1'b0;
    d_alu_src_b = 1'b0;
    d_alu_op    = 2'b00;
    d_reg_write = 1'b0;
    d_wb_sel    = 2'b00;
    d_illegal   = 1'b0;
    case (cur_state)
      FETCH: begin
        d_mem_req = 1'b1;
        if (mem_ready) begin
          d_ir_load = 1'b1;
          nxt_state = DECODE;
        end
      end
      DECODE: nxt_state = is_legal(opcode) ? EXEC : TRAP;
      EXEC: begin
        nxt_state = WB;
        case (opcode)
          OPC_OP:    d_alu_op = 2'b10;
          OPC_OPIMM: begin
            d_alu_op    = 2'b10;
            d_alu_src_b = 1'b1;
          end
          OPC_LOAD, OPC_STORE: begin
            d_alu_src_b = 1'b1;
            nxt_state   = MEM;
          end
          OPC_AUIPC: begin
            d_alu_src_a = 1'b1;
            d_alu_src_b = 1'b1;
          end
          OPC_JALR:  d_alu_src_b = 1'b1;
          OPC_BRANCH: begin
            d_alu_op  = 2'b01;
            d_pc_load = 1'b1;
            d_pc_src  = br_taken ? 2'b01 : 2'b00;
            nxt_state = FETCH;
          end
          OPC_JAL, OPC_LUI: nxt_state = WB;
          default:   nxt_state = TRAP;
        endcase
      end
      MEM: begin
        d_mem_req  = 1'b1;
        d_addr_sel = 1'b1;
        d_mem_we   = (opcode == OPC_STORE);
        if (mem_ready) begin
          if (opcode == OPC_STORE) begin
            d_pc_load = 1'b1;
            nxt_state = FETCH;
          end else begin
            nxt_state = WB;
          end
        end
      end
      WB: begin
        d_reg_write = 1'b1;
        d_pc_load   = 1'b1;
        nxt_state   = FETCH;
        case (opcode)
          OPC_LOAD: d_wb_sel = 2'b01;
          OPC_LUI:  d_wb_sel = 2'b11;
          OPC_JAL: begin
            d_wb_sel = 2'b10;
            d_pc_src = 2'b01;
          end
          OPC_JALR: begin
            d_wb_sel = 2'b10;
            d_pc_src = 2'b10;
          end
          default:  d_wb_sel = 2'b00;
        endcase
      end
      TRAP:    d_illegal = 1'b1;
      default: nxt_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= FETCH;
      boot      <= 1'b1;
      ret_count <= 32'd0;
    end else begin
      cur_state <= nxt_state;
      boot      <= 1'b0;
      if (d_pc_load) ret_count <= ret_count + 32'd1;
    end
  end

  // Outputs are forced low while reset is held so an in-flight access is dropped at once.
  assign mem_req   = reset_n & d_mem_req;
  assign mem_we    = reset_n & d_mem_we;
  assign addr_sel  = reset_n & d_addr_sel;
  assign ir_load   = reset_n & d_ir_load;
  assign pc_load   = reset_n & (d_pc_load | (RESET_PC_LOAD & boot));
  assign pc_src    = reset_n ? d_pc_src : 2'b00;
  assign alu_src_a = reset_n & d_alu_src_a;
  assign alu_src_b = reset_n & d_alu_src_b;
  assign alu_op    = reset_n ? d_alu_op : 2'b00;
  assign reg_write = reset_n & d_reg_write;
  assign wb_sel    = reset_n ? d_wb_sel : 2'b00;
  assign illegal   = reset_n & d_illegal;
  assign state     = reset_n ? cur_state : FETCH;
  assign instret   = ret_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction cycle scripts
// built from the opcode rules feed an expected-output queue drained by a negedge monitor.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_load;
  logic [1:0]  pc_src, alu_op, wb_sel;
  logic        alu_src_a, alu_src_b, reg_write, illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load), .pc_load(pc_load),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal(illegal), .state(state), .instret(instret)
  );

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req, mem_we, addr_sel, ir_load, pc_load;
    logic [1:0] pc_src;
    logic       alu_src_a, alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       c;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_ret = 32'd0;
  logic [6:0]  legal_ops [9];
  exp_t        mon_e;
  ctrl_t       mon_act;

  function automatic logic rnd();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic [6:0] rnd7();
    return 7'($urandom);
  endfunction

  function automatic logic legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ctrl_t fetch_c(input logic done);
    ctrl_t c;
    c = '0;
    c.mem_req = 1'b1;
    c.ir_load = done;
    return c;
  endfunction

  function automatic ctrl_t exec_c(input logic [6:0] op, input logic taken);
    ctrl_t c;
    c = '0;
    c.state = 3'd2;
    case (op)
      OPC_OP:    c.alu_op = 2'b10;
      OPC_OPIMM: begin c.alu_op = 2'b10; c.alu_src_b = 1'b1; end
      OPC_LOAD, OPC_STORE, OPC_JALR: c.alu_src_b = 1'b1;
      OPC_AUIPC: begin c.alu_src_a = 1'b1; c.alu_src_b = 1'b1; end
      OPC_BRANCH: begin
        c.alu_op  = 2'b01;
        c.pc_load = 1'b1;
        c.pc_src  = {1'b0, taken};
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t mem_c(input logic [6:0] op, input logic done);
    ctrl_t c;
    c = '0;
    c.state    = 3'd3;
    c.mem_req  = 1'b1;
    c.addr_sel = 1'b1;
    c.mem_we   = (op == OPC_STORE);
    c.pc_load  = done && (op == OPC_STORE);
    return c;
  endfunction

  function automatic ctrl_t wb_c(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    c.state     = 3'd4;
    c.reg_write = 1'b1;
    c.pc_load   = 1'b1;
    if (op == OPC_LOAD) c.wb_sel = 2'b01;
    if (op == OPC_LUI)  c.wb_sel = 2'b11;
    if (op == OPC_JAL)  begin c.wb_sel = 2'b10; c.pc_src = 2'b01; end
    if (op == OPC_JALR) begin c.wb_sel = 2'b10; c.pc_src = 2'b10; end
    return c;
  endfunction

  // One cycle: drive inputs just after the edge and queue the response expected in that cycle.
  task automatic emit(input logic rst, input logic mr, input logic bt,
                      input logic [6:0] op, input ctrl_t c);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n   = rst;
    mem_ready = mr;
    br_taken  = bt;
    opcode    = op;
    if (!rst) model_ret = 32'd0;
    e.c   = c;
    e.ret = model_ret;
    sb.push_back(e);
    if (c.pc_load) model_ret = model_ret + 32'd1;
  endtask

  task automatic do_reset(input int n);
    repeat (n) emit(1'b0, rnd(), rnd(), rnd7(), '0);
  endtask

  // abort_mem >= 0 asserts reset at that MEM cycle index instead of completing it.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic taken, input int abort_mem);
    ctrl_t c;
    for (int i = 0; i <= fw; i++) emit(1'b1, i == fw, rnd(), rnd7(), fetch_c(i == fw));
    c = '0;
    c.state = 3'd1;
    emit(1'b1, rnd(), rnd(), op, c);
    if (!legal(op)) begin
      c = '0;
      c.state   = 3'd5;
      c.illegal = 1'b1;
      repeat (3) emit(1'b1, rnd(), rnd(), rnd7(), c);
      do_reset(2);
      return;
    end
    emit(1'b1, rnd(), (op == OPC_BRANCH) ? taken : rnd(), op, exec_c(op, taken));
    if (op == OPC_BRANCH) return;
    if (op == OPC_LOAD || op == OPC_STORE) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == abort_mem) begin
          do_reset(2);
          return;
        end
        emit(1'b1, i == mw, rnd(), op, mem_c(op, i == mw));
      end
      if (op == OPC_STORE) return;
    end
    emit(1'b1, rnd(), rnd(), op, wb_c(op));
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = {state, mem_req, mem_we, addr_sel, ir_load, pc_load, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal};
      vectors++;
      if (mon_act !== mon_e.c) begin
        miscompares++;
        $display("FAIL ctrl t=%0t: actual state=%0d outs=%h required state=%0d outs=%h",
                 $time, mon_act.state, mon_act[14:0], mon_e.c.state, mon_e.c[14:0]);
      end
      vectors++;
      if (instret !== mon_e.ret) begin
        miscompares++;
        $display("FAIL instret t=%0t: actual %0d required %0d", $time, instret, mon_e.ret);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] op;
    int         fw, mw, ab;
    legal_ops = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
                  OPC_JAL, OPC_JALR, OPC_AUIPC, OPC_LUI};
    do_reset(3);
    run_instr(OPC_OP,     0, 0, 1'b0, -1);
    run_instr(OPC_LOAD,   0, 2, 1'b0, -1);
    run_instr(OPC_STORE,  0, 0, 1'b0, -1);
    run_instr(OPC_BRANCH, 0, 0, 1'b1, -1);
    run_instr(OPC_BRANCH, 0, 0, 1'b0, -1);
    run_instr(OPC_JAL,    0, 0, 1'b0, -1);
    run_instr(OPC_AUIPC,  0, 0, 1'b0, -1);
    run_instr(OPC_JALR,   1, 0, 1'b0, -1);
    run_instr(OPC_LUI,    0, 0, 1'b0, -1);
    run_instr(OPC_OPIMM,  2, 0, 1'b0, -1);
    run_instr(OPC_STORE,  1, 3, 1'b0, -1);
    run_instr(7'h00,      0, 0, 1'b0, -1);
    run_instr(OPC_OP,     0, 0, 1'b0, -1);
    run_instr(OPC_LOAD,   1, 3, 1'b0, 1);
    run_instr(OPC_STORE,  0, 2, 1'b0, 0);
    run_instr(OPC_OP,     0, 0, 1'b0, -1);
    repeat (250) begin
      if ($urandom_range(0, 19) == 0) begin
        op = rnd7();
        while (legal(op)) op = rnd7();
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      ab = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_instr(op, fw, mw, rnd(), ab);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I processor core. Sequences each instruction through fetch, decode, execute, memory and write-back. The immediate/register-field generator decodes the instruction register combinationally; this block drives the datapath select, enable and memory-request signals from the registered opcode. It also counts retired instructions and traps on unsupported opcodes.

## Interface
- `RESET_PC_LOAD`, default 0: when 1, `pc_load` pulses for one cycle on the first clock after reset release so the datapath reloads its reset vector. When 0, no pulse.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: `IR[6:0]`; valid from the cycle after `ir_load`.
- `mem_ready` in 1: memory completion for the current `mem_req`. Sampled on the rising edge.
- `br_taken` in 1: branch condition from the ALU comparator. Valid combinationally in EXEC.
- `mem_req` out 1: memory access request. Held until `mem_ready`.
- `mem_we` out 1: write request; only asserted with `mem_req`.
- `addr_sel` out 1: 0 = PC, 1 = ALUOut.
- `ir_load` out 1: capture memory read data into IR.
- `pc_load` out 1: update PC.
- `pc_src` out 2: 00 = PC+4, 01 = PC+imm, 10 = ALUOut.
- `alu_src_a` out 1: 0 = rs1, 1 = PC.
- `alu_src_b` out 1: 0 = rs2, 1 = imm.
- `alu_op` out 2: 00 = add, 01 = compare (branch), 10 = funct3/funct7 decode.
- `reg_write` out 1: register file write enable.
- `wb_sel` out 2: 00 = ALUOut, 01 = memory data, 10 = PC+4, 11 = imm.
- `illegal` out 1: trapped on unsupported opcode.
- `state` out 3: current state, for debug.
- `instret` out 32: retired-instruction counter.

## Operation
- Datapath registers ALU result into ALUOut every cycle.
- Supported opcodes:
  - LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011
  - BRANCH 1100011, JAL 1101111, JALR 1100111, AUIPC 0010111, LUI 0110111
- Any other opcode, including 0000000, is illegal.
- States (`state` encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - Outputs: `mem_req`=1, `addr_sel`=0.
  - Stays in FETCH while `mem_ready`=0.
  - When `mem_ready`=1: `ir_load`=1 in that same cycle, then DECODE.
- DECODE: one cycle, all outputs 0. Next state is EXEC for a legal opcode, TRAP otherwise.
- EXEC, per opcode:
  - OP: `alu_op`=10, srcs 0/0 -> WB.
  - OP-IMM: `alu_op`=10, `alu_src_b`=1 -> WB.
  - LOAD / STORE: `alu_op`=00, `alu_src_b`=1 -> MEM.
  - AUIPC: `alu_src_a`=1, `alu_src_b`=1, `alu_op`=00 -> WB.
  - JALR: `alu_src_b`=1, `alu_op`=00 -> WB.
  - JAL, LUI: no ALU use -> WB.
  - BRANCH: `alu_op`=01, `pc_load`=1, `pc_src` = `br_taken` ? 01 : 00; retires -> FETCH.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=1 for STORE. Stays in MEM while `mem_ready`=0. When `mem_ready`=1:
  - LOAD -> WB.
  - STORE: `pc_load`=1, `pc_src`=00, retires -> FETCH.
- WB: `reg_write`=1, `pc_load`=1, then FETCH.
  - LOAD: `wb_sel`=01, `pc_src`=00.
  - OP, OP-IMM, AUIPC: `wb_sel`=00, `pc_src`=00.
  - LUI: `wb_sel`=11, `pc_src`=00.
  - JAL: `wb_sel`=10, `pc_src`=01.
  - JALR: `wb_sel`=10, `pc_src`=10.
- TRAP: `illegal`=1, all other outputs 0. Stays in TRAP until `reset_n` falls.
- Retirement: `instret` increments by 1 on every edge where `pc_load`=1. Exception: the `RESET_PC_LOAD` pulse does not count. Wraps 0xFFFFFFFF -> 0.
- Outputs are Moore decodes of state + `opcode` (+ `br_taken` / `mem_ready` where noted). No output depends on `opcode` in FETCH.

## Timing
- Reset: while `reset_n`=0, state=FETCH, `instret`=0, and every output is 0. Outputs are gated combinationally, so `mem_req` drops in the same cycle that reset asserts.
- Reset mid-access abandons the access. No partial write may be committed by this block.
- Latency with zero-wait memory (`mem_ready`=1 on first request cycle):
  - BRANCH, STORE: 3 and 4 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle in FETCH or MEM adds 1.
- `mem_ready` asserted outside FETCH/MEM is ignored.
- `br_taken` is ignored outside BRANCH EXEC.

## Test plan
- Reset, then IR = R-type `add x3,x1,x2` (0x002081B3), `mem_ready` always 1 -> state sequence 0,1,2,4,0. `reg_write`=1 and `pc_load`=1 in WB only. `instret`=1.
- LOAD `lw x1,1(x0)` (0x00102083) with `mem_ready` held low for 2 MEM cycles -> MEM lasts 3 cycles with `mem_req`=1, `addr_sel`=1, `mem_we`=0. WB then has `wb_sel`=01. Total 7 cycles.
- STORE 0x00402223 -> MEM has `mem_we`=1, `pc_load`=1, `pc_src`=00, no `reg_write`. 4 cycles.
- BRANCH 0x00318463: `br_taken`=1 -> `pc_src`=01; `br_taken`=0 -> `pc_src`=00. Both 3 cycles.
- JAL 0x004005EF -> WB has `wb_sel`=10, `pc_src`=01. AUIPC 0x00001517 -> EXEC `alu_src_a`=1; WB `wb_sel`=00.
- IR=0x00000000 -> DECODE then TRAP with `illegal`=1, `instret` unchanged. Drop `reset_n` mid-MEM -> all outputs 0 immediately, and release restarts FETCH.
